// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//   Bus bundle between the two writeback requesters, the arbiter and the
//   register file.
//
//   req0_*   : execute-path writeback request (valid/addr/data, ready back)
//   req1_*   : load-path writeback request    (valid/addr/data, ready back)
//   we/waddr/wdata : registered register-file write port
//   chk_addr/chk_hit : hazard query (is a write to this register pending?)
//
//   Modports:
//     master : requester / register-file side (drives requests and queries)
//     slave  : arbiter side (drives readys, write port and hazard answer)
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    logic [AW-1:0] chk_addr;
    logic          chk_hit;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output chk_addr,
        input  req0_ready, req1_ready,
        input  we, waddr, wdata,
        input  chk_hit
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  chk_addr,
        output req0_ready, req1_ready,
        output we, waddr, wdata,
        output chk_hit
    );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Two-requester writeback arbiter in front of a single register-file write
//   port. Each requester owns a one-entry buffer; buffered writes are granted
//   one per cycle and registered onto we/waddr/wdata.
//
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst   : asynchronous active-low reset
//     ready : global pipeline enable, 0 freezes arbitration
//     bus   : wb_arbiter_if.slave (requests, write port, hazard query)
//
//   Ordering rules:
//     - both buffers valid, same address : older buffer first (write order)
//     - both buffers valid, other address: round-robin
//     - writes to register 0 are accepted and silently dropped
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ready,
    wb_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_0    = 2'd1,
        GRANT_1    = 2'd2
    } grant_e;

    // Per-requester buffers
    logic          buf0_valid;
    logic [AW-1:0] buf0_addr;
    logic [DW-1:0] buf0_data;
    logic          buf1_valid;
    logic [AW-1:0] buf1_addr;
    logic [DW-1:0] buf1_data;

    // age[n] = 1 means buffer n holds the older of two pending writes
    logic [1:0]    age;
    logic [1:0]    age_next;

    // Round-robin pointer: 1 means req1 is preferred at the next contention
    logic          rr_ptr;

    // Registered write port
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;

    grant_e        grant;
    logic          accept0;
    logic          accept1;
    logic          load0;
    logic          load1;
    logic          stay0;
    logic          stay1;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // A buffer can only take a new request while empty; reset forces both
    // readys low so nothing is accepted while the block is held in reset.
    assign bus.req0_ready = rst & ~buf0_valid;
    assign bus.req1_ready = rst & ~buf1_valid;

    // Address-0 requests complete the handshake but never occupy a buffer.
    assign accept0 = bus.req0_valid & bus.req0_ready;
    assign accept1 = bus.req1_valid & bus.req1_ready;
    assign load0   = accept0 & (bus.req0_addr != '0);
    assign load1   = accept1 & (bus.req1_addr != '0);

    // Grant selection: ready=0 blocks every grant; with two pending writes
    // to the same register the older one must go first, otherwise the
    // round-robin pointer picks.
    always_comb begin
        grant = GRANT_NONE;
        if (ready) begin
            if (buf0_valid && buf1_valid) begin
                if (buf0_addr == buf1_addr) begin
                    grant = age[1] ? GRANT_1 : GRANT_0;
                end else begin
                    grant = rr_ptr ? GRANT_1 : GRANT_0;
                end
            end else if (buf0_valid) begin
                grant = GRANT_0;
            end else if (buf1_valid) begin
                grant = GRANT_1;
            end
        end
    end

    // Buffers that remain pending across this edge
    assign stay0 = buf0_valid & (grant != GRANT_0);
    assign stay1 = buf1_valid & (grant != GRANT_1);

    // Age update: a granted buffer loses its age; a buffer loaded next to a
    // still-pending one makes the pending one older. Simultaneous loads
    // treat req1 as older.
    always_comb begin
        age_next = age;
        if (grant == GRANT_0) begin
            age_next[0] = 1'b0;
        end
        if (grant == GRANT_1) begin
            age_next[1] = 1'b0;
        end
        if (load0 && load1) begin
            age_next = 2'b10;
        end else if (load0 && stay1) begin
            age_next = 2'b10;
        end else if (load1 && stay0) begin
            age_next = 2'b01;
        end
    end

    // Write-port source mux for the granted buffer
    always_comb begin
        sel_addr = buf0_addr;
        sel_data = buf0_data;
        if (grant == GRANT_1) begin
            sel_addr = buf1_addr;
            sel_data = buf1_data;
        end
    end

    // Buffer 0: load only happens while empty, so load and grant never
    // collide on the same buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_valid <= 1'b0;
            buf0_addr  <= '0;
            buf0_data  <= '0;
        end else if (load0) begin
            buf0_valid <= 1'b1;
            buf0_addr  <= bus.req0_addr;
            buf0_data  <= bus.req0_data;
        end else if (grant == GRANT_0) begin
            buf0_valid <= 1'b0;
        end
    end

    // Buffer 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf1_valid <= 1'b0;
            buf1_addr  <= '0;
            buf1_data  <= '0;
        end else if (load1) begin
            buf1_valid <= 1'b1;
            buf1_addr  <= bus.req1_addr;
            buf1_data  <= bus.req1_data;
        end else if (grant == GRANT_1) begin
            buf1_valid <= 1'b0;
        end
    end

    // Age flags and round-robin pointer; the pointer moves away from
    // whichever requester was just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age    <= 2'b00;
            rr_ptr <= 1'b0;
        end else begin
            age <= age_next;
            if (grant != GRANT_NONE) begin
                rr_ptr <= (grant == GRANT_0);
            end
        end
    end

    // Registered write port: address/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (grant != GRANT_NONE) begin
            we_q    <= 1'b1;
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

    // Hazard query covers both buffers and the write being presented now.
    // Register 0 is never a hazard.
    always_comb begin
        bus.chk_hit = 1'b0;
        if (bus.chk_addr != '0) begin
            if ((buf0_valid && (buf0_addr == bus.chk_addr)) ||
                (buf1_valid && (buf1_addr == bus.chk_addr)) ||
                (we_q && (waddr_q == bus.chk_addr))) begin
                bus.chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed testbench for wb_arbiter. Inputs change and outputs are sampled
//   on the falling clock edge, so every sample sees the result of the rising
//   edge just before it.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    logic clk;
    logic rst;
    logic ready;
    int   checks;
    int   failures;

    wb_arbiter_if #(.AW(5), .DW(32)) bus ();

    wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return every requester input to idle
    task automatic drive_idle();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.chk_addr   = '0;
    endtask

    // Two-cycle reset pulse, released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        ready = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
    endtask

    // Reset values and readys gated by reset
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%0h exp=0", bus.we); end
        checks++; if (bus.waddr !== 5'd0) begin failures++; $display("[TB] FAIL reset_waddr got=%0h exp=0", bus.waddr); end
        checks++; if (bus.wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got=%0h exp=0", bus.wdata); end
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req0_ready got=%0h exp=0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req1_ready got=%0h exp=0", bus.req1_ready); end
        @(negedge clk);
        rst = 1'b1;
        bus.chk_addr = 5'd5;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req0_ready got=%0h exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req1_ready got=%0h exp=1", bus.req1_ready); end
        checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_chk_hit got=%0h exp=0", bus.chk_hit); end
        bus.chk_addr = '0;
    endtask

    // Lone req0 write: two-cycle latency, single-cycle we pulse
    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h11;
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.chk_addr = 5'd5;
        #1;
        checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL single_we_early got=%0h exp=0", bus.we); end
        checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("[TB] FAIL single_hit_buffer got=%0h exp=1", bus.chk_hit); end
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_ready_busy got=%0h exp=0", bus.req0_ready); end
        @(negedge clk);
        checks++; if (bus.we !== 1'b1) begin failures++; $display("[TB] FAIL single_we got=%0h exp=1", bus.we); end
        checks++; if (bus.waddr !== 5'd5) begin failures++; $display("[TB] FAIL single_waddr got=%0h exp=5", bus.waddr); end
        checks++; if (bus.wdata !== 32'h11) begin failures++; $display("[TB] FAIL single_wdata got=%0h exp=11", bus.wdata); end
        checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("[TB] FAIL single_hit_output got=%0h exp=1", bus.chk_hit); end
        @(negedge clk);
        checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL single_we_pulse got=%0h exp=0", bus.we); end
        checks++; if (bus.waddr !== 5'd5) begin failures++; $display("[TB] FAIL single_waddr_hold got=%0h exp=5", bus.waddr); end
        checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("[TB] FAIL single_hit_clear got=%0h exp=0", bus.chk_hit); end
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready_free got=%0h exp=1", bus.req0_ready); end
        drive_idle();
    endtask

    // Round-robin between different addresses. After reset req0 wins; a lone
    // req0 write then leaves the pointer favouring req1 for the next pair.
    task automatic test_round_robin();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL rr_req1_busy got=%0h exp=0", bus.req1_ready); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 32'hA}) begin failures++; $display("[TB] FAIL rr_first we/addr/data got=%0h/%0h/%0h exp=1/3/a", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd4, 32'hB}) begin failures++; $display("[TB] FAIL rr_second we/addr/data got=%0h/%0h/%0h exp=1/4/b", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 5'd4, 32'hB}) begin failures++; $display("[TB] FAIL rr_idle_hold we/addr/data got=%0h/%0h/%0h exp=0/4/b", bus.we, bus.waddr, bus.wdata); end
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'hC;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd2, 32'hC}) begin failures++; $display("[TB] FAIL rr_lone_req0 we/addr/data got=%0h/%0h/%0h exp=1/2/c", bus.we, bus.waddr, bus.wdata); end
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd4, 32'hB}) begin failures++; $display("[TB] FAIL rr_repeat_first we/addr/data got=%0h/%0h/%0h exp=1/4/b", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 32'hA}) begin failures++; $display("[TB] FAIL rr_repeat_second we/addr/data got=%0h/%0h/%0h exp=1/3/a", bus.we, bus.waddr, bus.wdata); end
        drive_idle();
    endtask

    // Same register from both paths in one cycle: req1 counts as older
    task automatic test_same_addr();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h1;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h2;
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.chk_addr = 5'd7;
        #1;
        checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("[TB] FAIL same_hit got=%0h exp=1", bus.chk_hit); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 32'h2}) begin failures++; $display("[TB] FAIL same_first we/addr/data got=%0h/%0h/%0h exp=1/7/2", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 32'h1}) begin failures++; $display("[TB] FAIL same_second we/addr/data got=%0h/%0h/%0h exp=1/7/1", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL same_done_we got=%0h exp=0", bus.we); end
        drive_idle();
    endtask

    // Register-0 write: handshake completes, nothing is written
    task automatic test_zero_addr();
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFF;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_accept got=%0h exp=1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0; bus.chk_addr = 5'd0;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_no_load got=%0h exp=1", bus.req1_ready); end
        checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("[TB] FAIL zero_chk_hit got=%0h exp=0", bus.chk_hit); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL zero_we_c%0d got=%0h exp=0", i, bus.we); end
        end
        drive_idle();
    endtask

    // ready=0 freezes grants but buffers still accept
    task automatic test_stall();
        do_reset();
        ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 32'h10;
        bus.chk_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL stall_we_c%0d got=%0h exp=0", i, bus.we); end
            checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("[TB] FAIL stall_hit_c%0d got=%0h exp=1", i, bus.chk_hit); end
            @(negedge clk);
            bus.req1_valid = 1'b0;
        end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_req1_loaded got=%0h exp=0", bus.req1_ready); end
        ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd9, 32'h99}) begin failures++; $display("[TB] FAIL stall_release we/addr/data got=%0h/%0h/%0h exp=1/9/99", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd10, 32'h10}) begin failures++; $display("[TB] FAIL stall_second we/addr/data got=%0h/%0h/%0h exp=1/a/10", bus.we, bus.waddr, bus.wdata); end
        drive_idle();
    endtask

    // Reset mid-operation drops everything pending
    task automatic test_reset_mid();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h55;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'h66;
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.we !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_we got=%0h exp=1", bus.we); end
        rst = 1'b0;
        bus.chk_addr = 5'd6;
        #1;
        checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL mid_we_async got=%0h exp=0", bus.we); end
        checks++; if (bus.waddr !== 5'd0) begin failures++; $display("[TB] FAIL mid_waddr got=%0h exp=0", bus.waddr); end
        checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("[TB] FAIL mid_chk_hit got=%0h exp=0", bus.chk_hit); end
        @(negedge clk);
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("[TB] FAIL mid_readys got=%0h exp=0", {bus.req0_ready, bus.req1_ready}); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin failures++; $display("[TB] FAIL mid_readys_release got=%0h exp=3", {bus.req0_ready, bus.req1_ready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.we !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_we_c%0d got=%0h exp=0", i, bus.we); end
        end
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ready    = 1'b1;
        drive_idle();
        $display("[TB] wb_arbiter directed tests");
        test_reset();
        test_single();
        test_round_robin();
        test_same_addr();
        test_zero_addr();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
